mem_stage_lsu: RTL and testbench

//  MEM-stage load/store unit; consumes EX/MEM pipeline-register outputs (MemRead/MemWrite/Funct3/ALU addr/Reg2).

---
 rtl/riscv_mem_pkg.sv | 68 ++++++
 rtl/lsu_load_align.sv | 48 ++++
 rtl/mem_stage_lsu.sv | 168 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// ---------------------------------------------------------------------------
// riscv_mem_pkg
//   Shared definitions for the MEM-stage load/store unit.
//   - FUNCT3_* : RV32I load/store funct3 encodings
//   - lsu_state_t : LSU sequencing states (IDLE -> WAIT -> DONE -> IDLE)
//   - helpers   : funct3 legality, alignment check, store byte-enables,
//                 store lane replication
// ---------------------------------------------------------------------------
package riscv_mem_pkg;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // Stores only have B/H/W; the unsigned forms exist for loads only.
    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            FUNCT3_B, FUNCT3_H, FUNCT3_W: ok = 1'b1;
            FUNCT3_BU, FUNCT3_HU:         ok = ~is_store;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // funct3[1:0] encodes the access size for every legal encoding:
    // 00 byte, 01 half, 10 word.
    function automatic logic access_aligned(input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        case (f3[1:0])
            2'b01:   ok = ~off[0];
            2'b10:   ok = (off == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Data is replicated into every lane so the byte enables alone pick
    // the destination bytes; no shifting by address is needed.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// ---------------------------------------------------------------------------
// lsu_load_align
//   Combinational load extractor: selects the addressed byte/halfword from
//   a 32-bit read word and sign- or zero-extends it according to funct3.
// Ports
//   rdata   in  32  raw word returned by the data memory
//   off     in  2   byte offset of the access (addr[1:0])
//   funct3  in  3   load funct3 (LB/LH/LW/LBU/LHU)
//   result  out 32  aligned, extended load value
// ---------------------------------------------------------------------------
module lsu_load_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (off)
            2'b00:   byte_sel = rdata[7:0];
            2'b01:   byte_sel = rdata[15:8];
            2'b10:   byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
    end

    // Halfword lane is chosen by addr[1]; addr[0] is guaranteed 0 upstream.
    assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = rdata;
        case (funct3)
            FUNCT3_B:  result = {{24{byte_sel[7]}}, byte_sel};
            FUNCT3_H:  result = {{16{half_sel[15]}}, half_sel};
            FUNCT3_W:  result = rdata;
            FUNCT3_BU: result = {24'h000000, byte_sel};
            FUNCT3_HU: result = {16'h0000, half_sel};
            default:   result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
//   MEM-stage load/store unit. Takes the EX/MEM pipeline-register outputs,
//   issues one request on a req/ack data bus, aligns and extends the load
//   result and holds the pipeline (StallMEM) until the access completes.
//
// Handshake: MemReq rises at the edge that enters WAIT and stays high with
//   MemWe/MemAddr/MemBe/MemWdata stable until a rising edge samples
//   MemAck=1 (or the TIMEOUT expires); MemAck is ignored while MemReq=0.
//   StallMEM is the enable-bar of the upstream pipeline registers: the
//   instruction is held while it is 1 and advances on the DONE-cycle edge.
//
// Ports
//   clk, reset            clock (rising edge), async active-high reset
//   MemReadMEM/WriteMEM   load / store present in MEM stage
//   Funct3MEM             access size/sign (RV32I funct3)
//   ALUMuxMEM             effective byte address
//   Reg2MEM               store source data
//   MemReq/We/Addr/Be/Wdata  registered bus request fields
//   MemRdata, MemAck      bus response
//   StallMEM              combinational pipeline hold
//   LoadDataMEM           registered load result
//   LoadValid, BusError   1 in the DONE cycle (load / timeout completion)
//   Misaligned, IllegalAcc 1-cycle pulses for dropped accesses
//   state_dbg             current FSM state
// ---------------------------------------------------------------------------
module mem_stage_lsu
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemReadMEM,
    input  logic                  MemWriteMEM,
    input  logic [2:0]            Funct3MEM,
    input  logic [ADDR_WIDTH-1:0] ALUMuxMEM,
    input  logic [31:0]           Reg2MEM,
    output logic                  MemReq,
    output logic                  MemWe,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [3:0]            MemBe,
    output logic [31:0]           MemWdata,
    input  logic [31:0]           MemRdata,
    input  logic                  MemAck,
    output logic                  StallMEM,
    output logic [31:0]           LoadDataMEM,
    output logic                  LoadValid,
    output logic                  Misaligned,
    output logic                  IllegalAcc,
    output logic                  BusError,
    output lsu_state_t            state_dbg
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    lsu_state_t    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [31:0]   load_aligned;

    logic acc, illegal, misal, start, timeout_hit;

    // Request decode. Illegal wins over misaligned so only one flag fires.
    assign acc     = MemReadMEM | MemWriteMEM;
    assign illegal = acc & ((MemReadMEM & MemWriteMEM) | ~funct3_legal(MemWriteMEM, Funct3MEM));
    assign misal   = acc & ~illegal & ~access_aligned(Funct3MEM, ALUMuxMEM[1:0]);
    assign start   = acc & ~illegal & ~misal;

    assign timeout_hit = (cnt == CNT_LAST);
    assign state_dbg   = state;

    // funct3 and offset are latched with the request so the aligner does
    // not depend on the (held but conceptually upstream) pipeline inputs.
    lsu_load_align u_align (
        .rdata  (MemRdata),
        .off    (off_q),
        .funct3 (f3_q),
        .result (load_aligned)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = WAIT;
            WAIT: if (MemAck || timeout_hit) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: the stall covers the issuing IDLE cycle and all of
    // WAIT, and drops in DONE so the pipeline moves on that edge.
    always_comb begin
        StallMEM = 1'b0;
        case (state)
            IDLE:    StallMEM = start;
            WAIT:    StallMEM = 1'b1;
            default: StallMEM = 1'b0;
        endcase
    end

    // Request / response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MemReq      <= 1'b0;
            MemWe       <= 1'b0;
            MemAddr     <= '0;
            MemBe       <= 4'b0000;
            MemWdata    <= 32'h0;
            LoadDataMEM <= 32'h0;
            LoadValid   <= 1'b0;
            Misaligned  <= 1'b0;
            IllegalAcc  <= 1'b0;
            BusError    <= 1'b0;
            cnt         <= '0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
        end else begin
            // Single-cycle indications default low.
            LoadValid  <= 1'b0;
            BusError   <= 1'b0;
            Misaligned <= (state == IDLE) & misal;
            IllegalAcc <= (state == IDLE) & illegal;

            case (state)
                IDLE: begin
                    if (start) begin
                        MemReq   <= 1'b1;
                        MemWe    <= MemWriteMEM;
                        MemAddr  <= {ALUMuxMEM[ADDR_WIDTH-1:2], 2'b00};
                        MemBe    <= store_be(Funct3MEM, ALUMuxMEM[1:0]);
                        MemWdata <= store_lanes(Funct3MEM, Reg2MEM);
                        f3_q     <= Funct3MEM;
                        off_q    <= ALUMuxMEM[1:0];
                        cnt      <= '0;
                    end
                end
                WAIT: begin
                    if (MemAck) begin
                        MemReq      <= 1'b0;
                        LoadDataMEM <= load_aligned;
                        LoadValid   <= ~MemWe;
                    end else if (timeout_hit) begin
                        MemReq      <= 1'b0;
                        LoadDataMEM <= 32'h0;
                        LoadValid   <= ~MemWe;
                        BusError    <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
    import riscv_mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        MemReadMEM, MemWriteMEM;
    logic [2:0]  Funct3MEM;
    logic [31:0] ALUMuxMEM, Reg2MEM;
    logic        MemReq, MemWe;
    logic [31:0] MemAddr;
    logic [3:0]  MemBe;
    logic [31:0] MemWdata, MemRdata;
    logic        MemAck, StallMEM;
    logic [31:0] LoadDataMEM;
    logic        LoadValid, Misaligned, IllegalAcc, BusError;
    lsu_state_t  state_dbg;

    mem_stage_lsu #(.ADDR_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .MemReadMEM(MemReadMEM), .MemWriteMEM(MemWriteMEM), .Funct3MEM(Funct3MEM),
        .ALUMuxMEM(ALUMuxMEM), .Reg2MEM(Reg2MEM),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemBe(MemBe),
        .MemWdata(MemWdata), .MemRdata(MemRdata), .MemAck(MemAck),
        .StallMEM(StallMEM), .LoadDataMEM(LoadDataMEM), .LoadValid(LoadValid),
        .Misaligned(Misaligned), .IllegalAcc(IllegalAcc), .BusError(BusError),
        .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    // observations captured by the driver
    int          obs_stalls, obs_waits;
    logic        obs_hung, obs_we, obs_lv, obs_berr, obs_req_done;
    logic [31:0] obs_addr, obs_wdata, obs_ld;
    logic [3:0]  obs_be;

    // independent reference for load extraction
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> (8 * off);
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b010:  return w;
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Called just after a rising edge; presents one access, plays the memory
    // (ack in the ack_wait-th WAIT cycle, 0 = never), returns after the edge
    // that ends the access with the inputs cleared.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdw, input int ack_wait);
        int cyc;
        MemReadMEM = rd; MemWriteMEM = wr; Funct3MEM = f3; ALUMuxMEM = addr; Reg2MEM = wd;
        MemAck = 1'b0;
        obs_stalls = 0; obs_waits = 0; obs_hung = 1'b0; obs_we = 1'b0;
        obs_addr = 32'h0; obs_wdata = 32'h0; obs_be = 4'h0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (MemReq) begin
                obs_waits++;
                if (obs_waits == 1) begin
                    obs_we = MemWe; obs_addr = MemAddr; obs_be = MemBe; obs_wdata = MemWdata;
                end
                MemAck   = (obs_waits == ack_wait);
                MemRdata = MemAck ? rdw : $urandom;
            end else begin
                MemAck = 1'b0;
            end
            if (!StallMEM) break;
            obs_stalls++;
            cyc++;
            if (cyc > 64) begin obs_hung = 1'b1; break; end
        end
        obs_lv = LoadValid; obs_ld = LoadDataMEM; obs_berr = BusError; obs_req_done = MemReq;
        @(posedge clk); #1;
        MemReadMEM = 1'b0; MemWriteMEM = 1'b0; MemAck = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        MemReadMEM = 0; MemWriteMEM = 0; Funct3MEM = 0; ALUMuxMEM = 0; Reg2MEM = 0;
        MemRdata = 0; MemAck = 0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({MemReq, MemWe, MemAddr, MemBe, MemWdata, StallMEM} !== '0) begin
            tests_failed++; $display("FAIL reset_bus: got req=%b we=%b addr=%h be=%b wd=%h stall=%b, want all 0",
                                     MemReq, MemWe, MemAddr, MemBe, MemWdata, StallMEM);
        end
        tests_run++;
        if ({LoadDataMEM, LoadValid, Misaligned, IllegalAcc, BusError} !== '0) begin
            tests_failed++; $display("FAIL reset_resp: got ld=%h lv=%b mis=%b ill=%b berr=%b, want all 0",
                                     LoadDataMEM, LoadValid, Misaligned, IllegalAcc, BusError);
        end
        tests_run++;
        if (state_dbg !== IDLE) begin
            tests_failed++; $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lb();
        exp_q.push_back(32'hFFFF_FF80);
        do_access(1, 0, FUNCT3_B, 32'h0000_1003, 32'h0, 32'h80FF_0000, 1);
        tests_run++;
        if (obs_hung !== 1'b0 || obs_stalls != 2 || obs_waits != 1) begin
            tests_failed++; $display("FAIL lb_timing: got hung=%b stalls=%0d waits=%0d want 0/2/1",
                                     obs_hung, obs_stalls, obs_waits);
        end
        tests_run++;
        if (obs_addr !== 32'h1000 || obs_be !== 4'b1000 || obs_we !== 1'b0) begin
            tests_failed++; $display("FAIL lb_req: got addr=%h be=%b we=%b want 00001000/1000/0",
                                     obs_addr, obs_be, obs_we);
        end
        exp_v = exp_q.pop_front();
        tests_run++;
        if (obs_lv !== 1'b1 || obs_ld !== exp_v) begin
            tests_failed++; $display("FAIL lb_data: got lv=%b data=%h want lv=1 data=%h", obs_lv, obs_ld, exp_v);
        end
        @(negedge clk);
        tests_run++;
        if (LoadValid !== 1'b0) begin
            tests_failed++; $display("FAIL lb_lv_clear: got %b want 0", LoadValid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sh();
        do_access(0, 1, FUNCT3_H, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 5);
        tests_run++;
        if (obs_hung !== 1'b0 || obs_stalls != 6) begin
            tests_failed++; $display("FAIL sh_stall: got hung=%b stalls=%0d want 0/6", obs_hung, obs_stalls);
        end
        tests_run++;
        if (obs_addr !== 32'h2000 || obs_be !== 4'b1100 || obs_wdata !== 32'hABCD_ABCD || obs_we !== 1'b1) begin
            tests_failed++; $display("FAIL sh_req: got addr=%h be=%b wd=%h we=%b want 00002000/1100/abcdabcd/1",
                                     obs_addr, obs_be, obs_wdata, obs_we);
        end
        tests_run++;
        if (obs_lv !== 1'b0 || obs_req_done !== 1'b0) begin
            tests_failed++; $display("FAIL sh_done: got lv=%b req=%b want 0/0", obs_lv, obs_req_done);
        end
    endtask

    task automatic test_misaligned();
        logic [2:0]  f3_t [0:2];
        logic [31:0] ad_t [0:2];
        logic        wr_t [0:2];
        f3_t = '{FUNCT3_W, FUNCT3_HU, FUNCT3_H};
        ad_t = '{32'h0000_0001, 32'h0000_0103, 32'h0000_0011};
        wr_t = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            do_access(~wr_t[i], wr_t[i], f3_t[i], ad_t[i], 32'h5555_AAAA, 32'h0, 1);
            tests_run++;
            if (obs_stalls != 0 || obs_waits != 0) begin
                tests_failed++; $display("FAIL mis_%0d_noreq: got stalls=%0d waits=%0d want 0/0", i, obs_stalls, obs_waits);
            end
            @(negedge clk);
            tests_run++;
            if (Misaligned !== 1'b1 || IllegalAcc !== 1'b0 || MemReq !== 1'b0) begin
                tests_failed++; $display("FAIL mis_%0d_pulse: got mis=%b ill=%b req=%b want 1/0/0",
                                         i, Misaligned, IllegalAcc, MemReq);
            end
            @(negedge clk);
            tests_run++;
            if (Misaligned !== 1'b0) begin
                tests_failed++; $display("FAIL mis_%0d_clear: got %b want 0", i, Misaligned);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic        rd_t [0:3];
        logic        wr_t [0:3];
        logic [2:0]  f3_t [0:3];
        logic [31:0] ad_t [0:3];
        rd_t = '{1'b1, 1'b1, 1'b0, 1'b1};
        wr_t = '{1'b0, 1'b1, 1'b1, 1'b1};
        f3_t = '{3'b011, FUNCT3_W, FUNCT3_BU, FUNCT3_W};
        ad_t = '{32'h0, 32'h0000_0040, 32'h0000_0080, 32'h0000_0001};
        for (int i = 0; i < 4; i++) begin
            do_access(rd_t[i], wr_t[i], f3_t[i], ad_t[i], 32'h0, 32'h0, 1);
            tests_run++;
            if (obs_stalls != 0 || obs_waits != 0) begin
                tests_failed++; $display("FAIL ill_%0d_noreq: got stalls=%0d waits=%0d want 0/0", i, obs_stalls, obs_waits);
            end
            @(negedge clk);
            tests_run++;
            if (IllegalAcc !== 1'b1 || Misaligned !== 1'b0 || MemReq !== 1'b0) begin
                tests_failed++; $display("FAIL ill_%0d_pulse: got ill=%b mis=%b req=%b want 1/0/0",
                                         i, IllegalAcc, Misaligned, MemReq);
            end
            @(negedge clk);
            tests_run++;
            if (IllegalAcc !== 1'b0) begin
                tests_failed++; $display("FAIL ill_%0d_clear: got %b want 0", i, IllegalAcc);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        exp_q.push_back(32'h0);
        do_access(1, 0, FUNCT3_W, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 0);
        tests_run++;
        if (obs_hung !== 1'b0 || obs_waits != 16 || obs_stalls != 17) begin
            tests_failed++; $display("FAIL to_timing: got hung=%b waits=%0d stalls=%0d want 0/16/17",
                                     obs_hung, obs_waits, obs_stalls);
        end
        exp_v = exp_q.pop_front();
        tests_run++;
        if (obs_berr !== 1'b1 || obs_ld !== exp_v || obs_req_done !== 1'b0 || obs_lv !== 1'b1) begin
            tests_failed++; $display("FAIL to_done: got berr=%b data=%h req=%b lv=%b want 1/%h/0/1",
                                     obs_berr, obs_ld, obs_req_done, obs_lv, exp_v);
        end
        @(negedge clk);
        tests_run++;
        if (BusError !== 1'b0) begin
            tests_failed++; $display("FAIL to_clear: got %b want 0", BusError);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        MemReadMEM = 1'b1; MemWriteMEM = 1'b0; Funct3MEM = FUNCT3_W; ALUMuxMEM = 32'h0000_0080;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (MemReq !== 1'b1 || state_dbg !== WAIT) begin
            tests_failed++; $display("FAIL rst_mid_wait: got req=%b state=%0d want 1/%0d", MemReq, state_dbg, WAIT);
        end
        reset = 1'b1;
        MemReadMEM = 1'b0;
        #1;
        tests_run++;
        if ({MemReq, MemWe, MemAddr, MemBe, StallMEM, LoadValid, BusError, LoadDataMEM} !== '0) begin
            tests_failed++; $display("FAIL rst_mid_clear: got req=%b addr=%h be=%b stall=%b lv=%b want all 0",
                                     MemReq, MemAddr, MemBe, StallMEM, LoadValid);
        end
        @(negedge clk);
        reset = 1'b0;
        MemAck = 1'b1; MemRdata = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (MemReq !== 1'b0 || LoadValid !== 1'b0 || LoadDataMEM !== 32'h0 || state_dbg !== IDLE) begin
                tests_failed++; $display("FAIL rst_mid_late_ack_%0d: got req=%b lv=%b ld=%h state=%0d want 0/0/0/IDLE",
                                         i, MemReq, LoadValid, LoadDataMEM, state_dbg);
            end
        end
        MemAck = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ld_tab [0:4];
        logic [2:0]  st_tab [0:2];
        logic [2:0]  f3;
        logic [31:0] addr, wd, rdw, exp_wd;
        logic [3:0]  exp_be;
        logic        is_st;
        int          aw;
        ld_tab = '{FUNCT3_B, FUNCT3_H, FUNCT3_W, FUNCT3_BU, FUNCT3_HU};
        st_tab = '{FUNCT3_B, FUNCT3_H, FUNCT3_W};
        for (int i = 0; i < 16; i++) begin
            is_st = ($urandom_range(0, 2) == 0);
            f3    = is_st ? st_tab[$urandom_range(0, 2)] : ld_tab[$urandom_range(0, 4)];
            addr  = $urandom;
            if (f3[1:0] == 2'b01) addr[0] = 1'b0;
            if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
            wd  = $urandom;
            rdw = $urandom;
            aw  = $urandom_range(1, 4);
            if (!is_st) exp_q.push_back(model_load(f3, addr[1:0], rdw));
            do_access(~is_st, is_st, f3, addr, wd, rdw, aw);
            tests_run++;
            if (obs_hung !== 1'b0 || obs_stalls != aw + 1 || obs_addr !== {addr[31:2], 2'b00} || obs_we !== is_st) begin
                tests_failed++; $display("FAIL b2b_%0d_req: got hung=%b stalls=%0d addr=%h we=%b want 0/%0d/%h/%b",
                                         i, obs_hung, obs_stalls, obs_addr, obs_we, aw + 1, {addr[31:2], 2'b00}, is_st);
            end
            if (is_st) begin
                case (f3[1:0])
                    2'b00:   begin exp_be = 4'b0001 << addr[1:0]; exp_wd = {4{wd[7:0]}}; end
                    2'b01:   begin exp_be = addr[1] ? 4'b1100 : 4'b0011; exp_wd = {2{wd[15:0]}}; end
                    default: begin exp_be = 4'b1111; exp_wd = wd; end
                endcase
                tests_run++;
                if (obs_be !== exp_be || obs_wdata !== exp_wd || obs_lv !== 1'b0) begin
                    tests_failed++; $display("FAIL b2b_%0d_store: got be=%b wd=%h lv=%b want %b/%h/0",
                                             i, obs_be, obs_wdata, obs_lv, exp_be, exp_wd);
                end
            end else begin
                exp_v = exp_q.pop_front();
                tests_run++;
                if (obs_lv !== 1'b1 || obs_ld !== exp_v || obs_berr !== 1'b0) begin
                    tests_failed++; $display("FAIL b2b_%0d_load: f3=%b off=%0d got lv=%b data=%h berr=%b want 1/%h/0",
                                             i, f3, addr[1:0], obs_lv, obs_ld, obs_berr, exp_v);
                end
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_lb();
        test_sh();
        test_misaligned();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL sb_drain: got %0d entries left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
